// File: rtl/cpu_out_port.sv
// cpu_out_port: memory-mapped output FIFO peripheral for the single-cycle core.
//
// Snoops the core's data-memory bus. Stores to DATA are pushed into a FIFO,
// and the FIFO is presented on a valid/ready stream. Register reads are
// combinational, so the core can fetch STATUS through its read mux.
//
// Register window (word offsets from BASE_ADDR; address[1:0] ignored):
//   +0x0 DATA   : write pushes data_in, read returns 0
//   +0x4 STATUS : {16'b0, level[7:0], 5'b0, overflow, full, empty}
//                 write with data_in[2]=1 clears overflow
//   +0x8 COUNT  : pop counter when CPU_OUT_PORT_COUNT_EN is defined, else reads 0
//   +0xC        : reserved, reads 0
//
// Optional feature macro: CPU_OUT_PORT_COUNT_EN (32-bit pop counter at +0x8).
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   we        in   store enable from the core
//   address   in   data address [31:0]
//   data_in   in   store data [31:0]
//   data_out  out  combinational register read value, 0 outside the window
//   sel       out  1 when address falls inside the 16-byte window
//   out_data  out  FIFO head word, 0 while empty
//   out_valid out  FIFO non-empty
//   out_ready in   consumer accepts the head this cycle
//
// Stream handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the head holds
// stable; out_ready while empty does nothing.

module cpu_out_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        sel,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = PW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    logic [1:0]    w_off;
    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_reject;
    logic          w_ovf_clr;
    logic [7:0]    w_level8;
    logic [31:0]   w_status;
    logic [31:0]   w_count_rd;
    logic          w_unused;

    // Byte-lane bits are ignored by the register decode.
    assign w_unused   = ^address[1:0];

    assign sel        = (address[31:4] == BASE_ADDR[31:4]);
    assign w_off      = address[3:2];

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(DEPTH));

    assign w_push_req = we & sel & (w_off == 2'd0);
    assign w_pop      = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_reject   = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = we & sel & (w_off == 2'd1) & data_in[2];

    assign out_valid  = ~w_empty;
    assign out_data   = w_empty ? 32'b0 : r_mem[r_rd_ptr];

    assign w_level8   = 8'(r_level);
    assign w_status   = {16'b0, w_level8, 5'b0, r_overflow, w_full, w_empty};

    // Storage is deliberately not reset; out_data is masked while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // Set has priority over a same-cycle clear.
            if (w_reject) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef CPU_OUT_PORT_COUNT_EN
    logic [31:0] r_count;
    logic        w_count_clr;

    assign w_count_clr = we & sel & (w_off == 2'd2);

    // Clear wins over a same-cycle pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= 32'b0;
        end else if (w_count_clr) begin
            r_count <= 32'b0;
        end else if (w_pop) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign w_count_rd = r_count;
`else
    assign w_count_rd = 32'b0;
`endif

    always_comb begin
        data_out = 32'b0;
        if (sel) begin
            case (w_off)
                2'd1:    data_out = w_status;
                2'd2:    data_out = w_count_rd;
                default: data_out = 32'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_out_port.sv
// Testbench for cpu_out_port. A queue-based reference model tracks the FIFO
// contents, the sticky overflow flag and the pop count; each test task drives
// the bus and compares DUT outputs against the model inline.

module tb_cpu_out_port;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clock;
    logic        reset;
    logic        we;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        sel;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] exp_q[$];
    logic        m_ovf;
    logic [31:0] m_count;

    cpu_out_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .we        (we),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model helpers ----------------
    function automatic logic [31:0] m_status();
        logic [7:0] lvl;
        lvl = 8'(exp_q.size());
        return {16'b0, lvl, 5'b0, m_ovf, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
    endfunction

    function automatic logic m_sel(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_sel(a)) return 32'b0;
        case (a[3:2])
            2'd1: return m_status();
`ifdef CPU_OUT_PORT_COUNT_EN
            2'd2: return m_count;
`endif
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_head();
        return (exp_q.size() != 0) ? exp_q[0] : 32'b0;
    endfunction

    // ---------------- driver tasks ----------------
    // Drive bus inputs well away from the clock edge and let them settle.
    task automatic apply(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        we        = w;
        address   = a;
        data_in   = d;
        out_ready = r;
        #1;
    endtask

    // Advance the model by the rules for the currently applied inputs, then clock.
    task automatic tick();
        bit pop, push_req, full, clr, cclr;
        pop      = (exp_q.size() != 0) && out_ready;
        full     = (exp_q.size() == DEPTH);
        push_req = we && m_sel(address) && (address[3:2] == 2'd0);
        clr      = we && m_sel(address) && (address[3:2] == 2'd1) && data_in[2];
        cclr     = we && m_sel(address) && (address[3:2] == 2'd2);
        if (clr) m_ovf = 1'b0;
        if (pop) begin
            void'(exp_q.pop_front());
            m_count = m_count + 32'd1;
        end
        if (push_req) begin
            if (!full || pop) exp_q.push_back(data_in);
            else m_ovf = 1'b1;
        end
        if (cclr) m_count = 32'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_count = 32'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle();
        #20;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b data=%h, required valid=0 data=0", out_valid, out_data);
        end
        reset = 1'b1;
        tick();
        apply(1'b0, 32'h0, 32'h0, 1'b0);
        n_tests++;
        if (sel !== 1'b0 || data_out !== 32'b0) begin
            n_fail++;
            $display("FAIL reset_sel0: sel=%b data_out=%h, required 0/0", sel, data_out);
        end
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++;
        if (sel !== 1'b1 || data_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL reset_status: sel=%b status=%h, required 1/00000001", sel, data_out);
        end
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, BASE, words[i], 1'b0);
            tick();
        end
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || data_out !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL basic_fill: valid=%b data=%h status=%h, required 1/0000000a/00000300",
                     out_valid, out_data, data_out);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, BASE + 32'h4, 32'h0, 1'b1);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== words[i]) begin
                n_fail++;
                $display("FAIL basic_drain[%0d]: valid=%b data=%h, required 1/%h", i, out_valid, out_data, words[i]);
            end
            tick();
        end
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'b0 || data_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL basic_empty: valid=%b data=%h status=%h, required 0/0/00000001",
                     out_valid, out_data, data_out);
        end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            apply(1'b1, BASE, i, 1'b0);
            tick();
        end
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== 32'h0000_0806) begin
            n_fail++;
            $display("FAIL ovf_status: status=%h, required 00000806", data_out);
        end
        for (int i = 1; i <= 8; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== i) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: valid=%b data=%h, required 1/%h", i, out_valid, out_data, i);
            end
            tick();
        end
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0 || data_out !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL ovf_after_drain: valid=%b status=%h, required 0/00000005", out_valid, data_out);
        end
        apply(1'b1, BASE + 32'h4, 32'h4, 1'b0);
        tick();
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL ovf_clear: status=%h, required 00000001", data_out);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] last;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, BASE, 32'h100 + i, 1'b0);
            tick();
        end
        apply(1'b1, BASE, 32'h55, 1'b1);
        tick();
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== 32'h0000_0802 || out_data !== 32'h101) begin
            n_fail++;
            $display("FAIL fullpp_status: status=%h head=%h, required 00000802/00000101", data_out, out_data);
        end
        last = 32'b0;
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1);
            n_tests++;
            if (out_data !== m_head()) begin
                n_fail++;
                $display("FAIL fullpp_drain[%0d]: data=%h, required %h", i, out_data, m_head());
            end
            last = out_data;
            tick();
        end
        n_tests++;
        if (last !== 32'h55 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_last: last=%h valid=%b, required 00000055/0", last, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_cnt;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, BASE, $urandom, 1'b0);
            tick();
        end
        idle();
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'b0) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b data=%h, required 0/0", out_valid, out_data);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        apply(1'b0, BASE + 32'h4, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL midreset_status: status=%h, required 00000001", data_out);
        end
        apply(1'b0, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_count: count=%h, required 0", data_out);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, BASE, 32'h70 + i, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1);
            tick();
        end
`ifdef CPU_OUT_PORT_COUNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        apply(1'b0, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== exp_cnt) begin
            n_fail++;
            $display("FAIL count_after_drain: count=%h, required %h", data_out, exp_cnt);
        end
        // clear in the same cycle as a pop must leave COUNT at 0
        apply(1'b1, BASE, 32'h99, 1'b0);
        tick();
        apply(1'b1, BASE + 32'h8, 32'h0, 1'b1);
        tick();
        apply(1'b0, BASE + 32'h8, 32'h0, 1'b0);
        n_tests++;
        if (data_out !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL count_clear_pop: count=%h valid=%b, required 0/0", data_out, out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        logic        r;
        int          sel_k;
        for (int c = 0; c < 400; c++) begin
            sel_k = $urandom_range(0, 9);
            case (sel_k)
                0, 1, 2, 3: a = BASE;
                4:          a = BASE + 32'h4 + $urandom_range(0, 3);
                5:          a = BASE + 32'h8;
                6:          a = BASE + 32'hC;
                7:          a = BASE - 32'h4;
                8:          a = BASE + 32'h10;
                default:    a = $urandom;
            endcase
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            apply(w, a, $urandom, r);
            n_tests++;
            if (out_valid !== (exp_q.size() != 0) || out_data !== m_head() ||
                sel !== m_sel(a) || data_out !== m_read(a)) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h valid=%b data=%h sel=%b rd=%h, required valid=%b data=%h sel=%b rd=%h",
                         c, a, out_valid, out_data, sel, data_out,
                         (exp_q.size() != 0), m_head(), m_sel(a), m_read(a));
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        we        = 1'b0;
        address   = 32'h0;
        data_in   = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
